// File: rtl/bus_arbiter.sv
// Round-robin owner selection and burst sequencing for the shared 32-bit tri-state bus.
// Produces the one-hot buffer enables and captures the bus value on every beat.
//
//  state | meaning
//  IDLE  | no owner; arbitrate among pending requests each cycle
//  DRIVE | one beat per cycle from the granted source until beat_cnt hits 0
//  TURN  | bus released, all cs low, turn_cnt counts down to 0
module bus_arbiter #(
  parameter int N        = 4,
  parameter int LEN_W    = 4,
  parameter int TURN_CYC = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N-1:0]       req,
  input  logic [N*LEN_W-1:0] len,
  input  logic [31:0]        bus_in,
  output logic [N-1:0]       grant_cs,
  output logic [2:0]         grant_id,
  output logic               busy,
  output logic               last,
  output logic [31:0]        cap_data,
  output logic               cap_valid
);

  typedef enum logic [1:0] {IDLE, DRIVE, TURN} state_t;

  state_t           state;
  logic [2:0]       ptr;
  logic [LEN_W-1:0] beat_cnt;
  logic [3:0]       turn_cnt;

  logic [2*N-1:0]   req_dbl;
  logic [N-1:0]     req_rot;
  logic [3:0]       idx;
  logic [2:0]       winner;
  logic             win_valid;
  logic [N-1:0]     win_onehot;
  logic [LEN_W-1:0] len_win;
  logic [2:0]       next_ptr;

  // Rotate requests so bit 0 is the current priority holder; the lowest set bit wins.
  always_comb begin
    req_dbl = {req, req};
    req_rot = N'(req_dbl >> ptr);
    idx     = 4'(ptr);
    for (int k = N - 1; k >= 0; k--) begin
      if (req_rot[k]) idx = 4'(ptr) + 4'(k);
    end
    winner    = (idx >= 4'(N)) ? 3'(idx - 4'(N)) : 3'(idx);
    win_valid = |req;
  end

  always_comb begin
    win_onehot = '0;
    len_win    = '0;
    for (int k = 0; k < N; k++) begin
      if (3'(k) == winner) begin
        win_onehot[k] = 1'b1;
        len_win       = len[k*LEN_W +: LEN_W];
      end
    end
  end

  assign next_ptr = (grant_id == 3'(N - 1)) ? 3'd0 : grant_id + 3'd1;
  assign last     = (state == DRIVE) && (beat_cnt == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      grant_cs  <= '0;
      grant_id  <= '0;
      busy      <= 1'b0;
      cap_data  <= '0;
      cap_valid <= 1'b0;
      ptr       <= '0;
      beat_cnt  <= '0;
      turn_cnt  <= '0;
    end else begin
      cap_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (win_valid) begin
            grant_cs <= win_onehot;
            grant_id <= winner;
            beat_cnt <= len_win;
            busy     <= 1'b1;
            state    <= DRIVE;
          end
        end
        DRIVE: begin
          cap_data  <= bus_in;
          cap_valid <= 1'b1;
          if (beat_cnt != '0) begin
            beat_cnt <= beat_cnt - LEN_W'(1);
          end else begin
            grant_cs <= '0;
            grant_id <= '0;
            busy     <= 1'b0;
            ptr      <= next_ptr;
            if (TURN_CYC > 0) begin
              turn_cnt <= 4'(TURN_CYC - 1);
              state    <= TURN;
            end else begin
              state <= IDLE;
            end
          end
        end
        TURN: begin
          if (turn_cnt == 4'd0) state <= IDLE;
          else                  turn_cnt <= turn_cnt - 4'd1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/bus_arbiter.md
Name: bus_arbiter

Overview:
- Round-robin arbiter and sequencer for the shared 32-bit tri-state data bus.
- Generates the one-hot chip-select vector that drives the cs inputs of the per-source 32-bit tri-state buffers.
- Holds one grant for a multi-beat burst, inserts bus-release (turnaround) cycles between owners, and captures the bus value on every beat for the consumer downstream.
- Guarantees that at most one driver is enabled at any time.

Parameters:
- N, 4, number of bus sources and requesters (2..8).
- LEN_W, 4, width of the per-requester burst-length field; a burst is len+1 beats, max 2^LEN_W.
- TURN_CYC, 1, number of idle cycles with all cs low after each burst (0..15).

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- rst  input  1  synchronous, active-high reset.
- req  input  N  per-source bus request; level-sensitive.
- len  input  N*LEN_W  per-source burst length minus one; source i uses bits [i*LEN_W +: LEN_W].
- bus_in  input  32  value read back from the shared tri-state bus.
- grant_cs  output  N  one-hot cs to the tri-state buffers; all-zero when no owner.
- grant_id  output  3  index of the current owner; valid while busy=1.
- busy  output  1  high while a burst is in progress (DRIVE state).
- last  output  1  high during the final beat of a burst.
- cap_data  output  32  bus value registered on each beat.
- cap_valid  output  1  one-cycle pulse, cycle after each beat.

Behaviour:
- Reset (synchronous, rst=1 at an edge):
  - state=IDLE, grant_cs=0, grant_id=0, busy=0, last=0, cap_data=0, cap_valid=0.
  - Priority pointer ptr=0, beat counter=0, turn counter=0.
  - rst mid-burst drops grant_cs to 0 at that edge; the remaining beats are discarded and no cap_valid is produced.
- States: IDLE, DRIVE, TURN.
- IDLE:
  - If req!=0, the winner is the first set bit scanning ptr, ptr+1, ... mod N.
  - At the edge: grant_cs=onehot(winner), grant_id=winner, beat counter loaded with len[winner], busy=1, go to DRIVE.
  - Latency: req high in cycle t (IDLE) gives grant_cs in cycle t+1.
  - If req=0, stay in IDLE with all outputs low.
- DRIVE:
  - Each cycle is one beat; the bus is driven by the owner's buffer.
  - At the edge: cap_data<=bus_in, cap_valid<=1.
  - last=1 combinationally when beat counter==0.
  - If counter!=0: decrement and stay in DRIVE.
  - If counter==0:
    - grant_cs=0, busy=0, ptr=(grant_id+1) mod N.
    - Go to TURN with turn counter=TURN_CYC-1 if TURN_CYC>0; otherwise go straight to IDLE.
  - The burst is committed once granted: req or len changes during DRIVE are ignored, including the owner deasserting req.
- TURN:
  - grant_cs=0. Decrement the turn counter; go to IDLE when it is 0.
  - Requests are not sampled in TURN.
- Sampling rules:
  - len is sampled only at the grant edge.
  - A req pulse that rises and falls entirely outside IDLE is lost; requesters hold req until they see their cs bit.
- Fairness:
  - After a burst by source k, source k has lowest priority.
  - With all N requesting continuously, grants rotate 0,1,...,N-1,0,...
- Invariants:
  - popcount(grant_cs)<=1 in every cycle.
  - grant_cs!=0 iff state==DRIVE.
  - cap_valid never high in the cycle after an IDLE or TURN cycle.
- Beat counter width is LEN_W; len=all-ones gives 2^LEN_W beats with no overflow.
- Back-to-back bursts from one source are separated by TURN_CYC+1 cycles with all cs low: the TURN cycles plus one IDLE arbitration cycle.

Test Plan:
- Reset then idle: rst=1 for 2 cycles, req=0 for 10 cycles -> grant_cs=0000, busy=0 and cap_valid=0 throughout.
- Single beat: req=0010, len[1]=0, bus_in=32'hDEADBEEF -> grant_cs=0010 for exactly 1 cycle with last=1; next cycle cap_valid=1 and cap_data=DEADBEEF; then grant_cs=0 for 1 TURN cycle.
- Burst of 4: req=0001, len[0]=3, bus_in=1,2,3,4 on successive beats -> grant_cs=0001 for 4 cycles, last only on the 4th; cap_data sequence 1,2,3,4, each with a cap_valid pulse.
- Round-robin: req=1111 held, all len=0, TURN_CYC=1 -> grant order 0,1,2,3,0.
  - Each grant is separated by 2 cycles of grant_cs=0.
  - Multiple cs bits are never high at once.
- Committed burst: req=0100, len[2]=5; drop req and raise req=0001 on beat 2 -> source 2 completes all 6 beats; source 0 is granted at the end of the 6th beat + TURN + 1 IDLE cycle.
- Mid-burst reset: len[3]=7, assert rst on beat 3 -> grant_cs=0 and busy=0 the next cycle, no further cap_valid, ptr=0.
  - With req=1000 still high after reset, source 3 is granted again 1 cycle after rst falls.
